// File: rtl/tile_ram_writer_pkg.sv
// Shared types for the tile-map RAM writer: FSM states, cursor commands,
// control codes and the 16-bit tile word layout.
package tile_ram_writer_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CUR_W  = 8;

  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_FF = 8'h0C;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WRITE,
    CLEAR,
    ROW_END,
    SCROLL_RD,
    SCROLL_WR,
    SCROLL_CLR
  } state_e;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADV,
    CUR_CR,
    CUR_LF,
    CUR_HOME,
    CUR_BOTTOM
  } cur_cmd_e;

  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] chr;
  } tile_word_t;

  function automatic tile_word_t make_tile(input logic [7:0] chr, input logic [7:0] attr);
    tile_word_t w;
    w.attr = attr;
    w.chr  = chr;
    return w;
  endfunction

endpackage

// File: rtl/tile_ram_writer_cursor.sv
// Cursor counters for the tile writer: column/row registers, end-of-row and
// end-of-screen detection, and the RAM word address of the current cell.
module tile_ram_writer_cursor
  import tile_ram_writer_pkg::*;
#(
  parameter int unsigned COLS      = 32,
  parameter int unsigned ROWS      = 30,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  cur_cmd_e          cmd_i,
  output logic [CUR_W-1:0]  x_o,
  output logic [CUR_W-1:0]  y_o,
  output logic              last_col_o,
  output logic              last_row_o,
  output logic [ADDR_W-1:0] cell_addr_o
);

  logic [CUR_W-1:0] x_q, x_d, y_q, y_d;

  assign last_col_o  = (x_q == CUR_W'(COLS - 1));
  assign last_row_o  = (y_q == CUR_W'(ROWS - 1));
  assign cell_addr_o = BASE_ADDR + ADDR_W'(y_q) * ADDR_W'(COLS) + ADDR_W'(x_q);
  assign x_o         = x_q;
  assign y_o         = y_q;

  // Row advance on the last row holds y; the writer FSM handles the row end.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    case (cmd_i)
      CUR_ADV: begin
        if (last_col_o) begin
          x_d = '0;
          if (!last_row_o) y_d = y_q + CUR_W'(1);
        end else begin
          x_d = x_q + CUR_W'(1);
        end
      end
      CUR_CR: x_d = '0;
      CUR_LF: begin
        x_d = '0;
        if (!last_row_o) y_d = y_q + CUR_W'(1);
      end
      CUR_HOME: begin
        x_d = '0;
        y_d = '0;
      end
      CUR_BOTTOM: begin
        x_d = '0;
        y_d = CUR_W'(ROWS - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/tile_ram_writer.sv
// Write-side client of the tile-map RAM: places char/attr tiles at a managed
// cursor, handles LF/CR/FF, and only touches RAM when ram_busy is low.
// Build option TILE_RAM_WRITER_SCROLL_EN makes the screen scroll at the bottom
// row; without it the cursor wraps back to row 0.
module tile_ram_writer
  import tile_ram_writer_pkg::*;
#(
  parameter int unsigned COLS       = 32,
  parameter int unsigned ROWS       = 30,
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter logic [15:0] CLEAR_WORD = 16'h0020
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  input  logic [7:0]        char_attr,
  output logic              char_ready,
  input  logic              ram_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_write,
  output logic              ram_writeenable,
  input  logic [WORD_W-1:0] ram_read,
  output logic [CUR_W-1:0]  cursor_x,
  output logic [CUR_W-1:0]  cursor_y,
  output logic              op_busy
);

  localparam int unsigned   CELLS    = COLS * ROWS;
  localparam logic [15:0]   LAST_IDX = 16'(CELLS - 1);
`ifdef TILE_RAM_WRITER_SCROLL_EN
  localparam logic [15:0]   ROW1_IDX     = 16'(COLS);
  localparam logic [15:0]   LAST_ROW_IDX = 16'(CELLS - COLS);
  localparam logic          SCROLL_EN    = 1'b1;
`else
  localparam logic          SCROLL_EN    = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [15:0]       idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  tile_word_t        wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              op_busy_q, op_busy_d;
  logic              wr_req;
  cur_cmd_e          cur_cmd;
  logic              last_col, last_row;
  logic [ADDR_W-1:0] cell_addr;
`ifdef TILE_RAM_WRITER_SCROLL_EN
  logic              have_q, have_d;
`else
  logic              unused_read;
  assign unused_read = ^ram_read;
`endif

  tile_ram_writer_cursor #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .BASE_ADDR (BASE_ADDR)
  ) u_cursor (
    .clk         (clk),
    .rst_n       (reset),
    .cmd_i       (cur_cmd),
    .x_o         (cursor_x),
    .y_o         (cursor_y),
    .last_col_o  (last_col),
    .last_row_o  (last_row),
    .cell_addr_o (cell_addr)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_req  = 1'b0;
    cur_cmd = CUR_NONE;
`ifdef TILE_RAM_WRITER_SCROLL_EN
    have_d  = have_q;
`endif
    case (state_q)
      IDLE: begin
        if (char_valid && ready_q) begin
          wdata_d = make_tile(char_data, char_attr);
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (wdata_q.chr)
          CC_LF: begin
            cur_cmd = CUR_LF;
            state_d = last_row ? ROW_END : IDLE;
          end
          CC_CR: begin
            cur_cmd = CUR_CR;
            state_d = IDLE;
          end
          CC_FF: begin
            idx_d   = '0;
            addr_d  = BASE_ADDR;
            wdata_d = tile_word_t'(CLEAR_WORD);
            state_d = CLEAR;
          end
          default: begin
            addr_d  = cell_addr;
            state_d = WRITE;
          end
        endcase
      end
      WRITE: begin
        wr_req = 1'b1;
        if (!ram_busy) begin
          cur_cmd = CUR_ADV;
          state_d = (last_col && last_row) ? ROW_END : IDLE;
        end
      end
      // Both sweeps hold their index while the renderer owns the RAM.
      CLEAR, SCROLL_CLR: begin
        wr_req = 1'b1;
        if (!ram_busy) begin
          if (idx_q == LAST_IDX) begin
            cur_cmd = (state_q == CLEAR) ? CUR_HOME : CUR_BOTTOM;
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + 16'd1;
            addr_d = BASE_ADDR + idx_q + 16'd1;
          end
        end
      end
`ifdef TILE_RAM_WRITER_SCROLL_EN
      ROW_END: begin
        idx_d   = ROW1_IDX;
        addr_d  = BASE_ADDR + ROW1_IDX;
        state_d = SCROLL_RD;
      end
      SCROLL_RD: begin
        if (!ram_busy) begin
          have_d  = 1'b0;
          state_d = SCROLL_WR;
        end
      end
      // First cycle is the read-data cycle; a busy data cycle re-reads.
      SCROLL_WR: begin
        if (!have_q) begin
          if (ram_busy) begin
            state_d = SCROLL_RD;
          end else begin
            wdata_d = tile_word_t'(ram_read);
            addr_d  = BASE_ADDR + idx_q - ROW1_IDX;
            have_d  = 1'b1;
          end
        end else begin
          wr_req = 1'b1;
          if (!ram_busy) begin
            have_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              idx_d   = LAST_ROW_IDX;
              addr_d  = BASE_ADDR + LAST_ROW_IDX;
              wdata_d = tile_word_t'(CLEAR_WORD);
              state_d = SCROLL_CLR;
            end else begin
              idx_d   = idx_q + 16'd1;
              addr_d  = BASE_ADDR + idx_q + 16'd1;
              state_d = SCROLL_RD;
            end
          end
        end
      end
`else
      ROW_END: begin
        cur_cmd = CUR_HOME;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign ready_d   = (state_d == IDLE);
  assign op_busy_d = (state_d == CLEAR) || (state_d == SCROLL_RD) || (state_d == SCROLL_WR) ||
                     (state_d == SCROLL_CLR) || (SCROLL_EN && (state_d == ROW_END));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_q    <= BASE_ADDR;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      op_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      op_busy_q <= op_busy_d;
    end
  end

`ifdef TILE_RAM_WRITER_SCROLL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) have_q <= 1'b0;
    else        have_q <= have_d;
  end
`endif

  // The strobe is gated by the live ram_busy so it can never overlap the renderer.
  assign ram_writeenable = wr_req && !ram_busy;
  assign ram_addr        = addr_q;
  assign ram_write       = wdata_q;
  assign char_ready      = ready_q;
  assign op_busy         = op_busy_q;

endmodule

// File: tb/tb_tile_ram_writer.sv
// Self-checking bench for tile_ram_writer: sync RAM model with a renderer that
// corrupts busy cycles, plus a screen-level reference model of the cursor/RAM.
`timescale 1ns/1ps
module tb_tile_ram_writer;
  import tile_ram_writer_pkg::*;

  localparam int          COLS  = 32;
  localparam int          ROWS  = 30;
  localparam int          CELLS = COLS * ROWS;
  localparam logic [15:0] CLR   = 16'h0020;
  localparam int          LIMIT = 20000;
`ifdef TILE_RAM_WRITER_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0, char_valid = 1'b0, ram_busy = 1'b0;
  logic [7:0]  char_data = 8'h00, char_attr = 8'h00;
  logic        char_ready, ram_writeenable, op_busy;
  logic [15:0] ram_addr, ram_write, ram_read;
  logic [7:0]  cursor_x, cursor_y;

  int checks = 0, errors = 0;
  int cyc = 0, viol = 0, busy_mode = 0;
  int mx = 0, my = 0;
  logic [15:0] mem [0:1023];
  logic [15:0] exp_mem [0:1023];
  logic [15:0] rd_q = 16'h0, junk = 16'h0;
  logic [15:0] log_addr[$], log_data[$];
  int          log_cyc[$];

  tile_ram_writer dut (
    .clk (clk), .reset (reset), .char_valid (char_valid), .char_data (char_data),
    .char_attr (char_attr), .char_ready (char_ready), .ram_busy (ram_busy),
    .ram_addr (ram_addr), .ram_write (ram_write), .ram_writeenable (ram_writeenable),
    .ram_read (ram_read), .cursor_x (cursor_x), .cursor_y (cursor_y), .op_busy (op_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    return 16'((i * 40503) + 4660);
  endfunction

  // Sync RAM; whatever the renderer owns shows up as junk on the read port.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (ram_writeenable && !ram_busy && ram_addr < 16'd1024) begin
      mem[ram_addr[9:0]] <= ram_write;
    end
    rd_q <= ram_busy ? 16'($urandom) : mem[ram_addr[9:0]];
    junk <= 16'($urandom);
  end
  assign ram_read = ram_busy ? junk : rd_q;

  always @(negedge clk) begin
    if (ram_writeenable) begin
      if (ram_busy) viol <= viol + 1;
      log_addr.push_back(ram_addr);
      log_data.push_back(ram_write);
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (busy_mode)
        0:       ram_busy = 1'b0;
        1:       ram_busy = ~ram_busy;
        default: ram_busy = ($urandom_range(2) == 0);
      endcase
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Screen-level reference model.
  function automatic void model_row_end();
    if (SCROLL) begin
      for (int i = 0; i < CELLS - COLS; i++) exp_mem[i] = exp_mem[i + COLS];
      for (int i = CELLS - COLS; i < CELLS; i++) exp_mem[i] = CLR;
      my = ROWS - 1;
    end else begin
      my = 0;
    end
    mx = 0;
  endfunction

  function automatic void model_put(input logic [7:0] c, input logic [7:0] a);
    if (c == CC_LF) begin
      mx = 0;
      if (my == ROWS - 1) model_row_end(); else my++;
    end else if (c == CC_CR) begin
      mx = 0;
    end else if (c == CC_FF) begin
      for (int i = 0; i < CELLS; i++) exp_mem[i] = CLR;
      mx = 0; my = 0;
    end else begin
      exp_mem[my * COLS + mx] = {a, c};
      mx++;
      if (mx == COLS) begin
        mx = 0;
        if (my == ROWS - 1) model_row_end(); else my++;
      end
    end
  endfunction

  function automatic int mem_diffs(output int first);
    int n = 0;
    first = 0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (mem[i] !== exp_mem[i]) begin first = i; n++; end
    end
    return n;
  endfunction

  task automatic send_char(input logic [7:0] c, input logic [7:0] a, output int acc);
    int n = 0;
    @(negedge clk);
    char_valid = 1'b1; char_data = c; char_attr = a;
    while (!char_ready && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) begin
      checks++; errors++;
      $display("FAIL send_ready: char_ready stayed %0b for %0d cycles, need 1", char_ready, n);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    char_valid = 1'b0;
    char_data = 8'($urandom);
    model_put(c, a);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!(char_ready && !op_busy) && n < LIMIT) begin @(negedge clk); n++; end
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles (ready=%0b op_busy=%0b)", n, char_ready, op_busy);
    end
  endtask

  task automatic put(input logic [7:0] c, input logic [7:0] a);
    int acc;
    send_char(c, a, acc);
    wait_done();
  endtask

  task automatic test_reset();
    busy_mode = 0;
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = pat(i);
    repeat (3) @(negedge clk);
    checks++;
    if ({char_ready, ram_writeenable, op_busy} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: ready/we/op_busy=%b, need 000", {char_ready, ram_writeenable, op_busy}); end
    checks++;
    if (ram_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h, need 0000", ram_addr); end
    checks++;
    if (ram_write !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h, need 0000", ram_write); end
    checks++;
    if ({cursor_x, cursor_y} !== 16'h0000) begin errors++;
      $display("FAIL reset_cursor: got (%0d,%0d), need (0,0)", cursor_x, cursor_y); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (char_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, need 1", char_ready); end
  endtask

  task automatic test_first_char();
    int acc, ls;
    ls = log_addr.size();
    send_char(8'h41, 8'h07, acc);
    @(negedge clk);
    checks++;
    if (char_ready !== 1'b0) begin errors++; $display("FAIL first_ready_drop: got %b, need 0", char_ready); end
    repeat (2) @(negedge clk);
    checks++;
    if (char_ready !== 1'b1) begin errors++; $display("FAIL first_ready_back: got %b, need 1", char_ready); end
    wait_done();
    checks++;
    if (log_addr.size() - ls !== 1) begin errors++;
      $display("FAIL first_count: %0d writes, need 1", log_addr.size() - ls);
    end else begin
      checks++;
      if (log_addr[ls] !== 16'h0000 || log_data[ls] !== 16'h0741) begin errors++;
        $display("FAIL first_write: addr %h data %h, need 0000 0741", log_addr[ls], log_data[ls]); end
      checks++;
      if (log_cyc[ls] !== acc + 1) begin errors++;
        $display("FAIL first_latency: write edge %0d, need %0d", log_cyc[ls] + 1, acc + 2); end
    end
    checks++;
    if (cursor_x !== 8'd1 || cursor_y !== 8'd0) begin errors++;
      $display("FAIL first_cursor: got (%0d,%0d), need (1,0)", cursor_x, cursor_y); end
  endtask

  task automatic test_row_wrap();
    int ls, fi, nd;
    logic [7:0] a;
    put(CC_CR, 8'h00);
    ls = log_addr.size();
    a = 8'h00;
    for (int i = 0; i < COLS; i++) begin a = 8'($urandom); put(8'h42, a); end
    checks++;
    if (log_addr.size() - ls !== COLS) begin errors++;
      $display("FAIL wrap_count: %0d writes, need %0d", log_addr.size() - ls, COLS);
    end else begin
      checks++;
      if (log_addr[ls + COLS - 1] !== 16'h001F || log_data[ls + COLS - 1] !== {a, 8'h42}) begin errors++;
        $display("FAIL wrap_last: addr %h data %h, need 001f %h", log_addr[ls + COLS - 1],
                 log_data[ls + COLS - 1], {a, 8'h42}); end
    end
    checks++;
    if (cursor_x !== 8'd0 || cursor_y !== 8'd1) begin errors++;
      $display("FAIL wrap_cursor: got (%0d,%0d), need (0,1)", cursor_x, cursor_y); end
    nd = mem_diffs(fi);
    checks++;
    if (nd != 0) begin errors++;
      $display("FAIL wrap_mem: %0d cells differ, first %0d got %h need %h", nd, fi, mem[fi], exp_mem[fi]); end
  endtask

  task automatic test_cr_lf();
    int ls, guard;
    guard = 0;
    put(CC_CR, 8'h00);
    while (my != 3 && guard < ROWS) begin put(CC_LF, 8'h00); guard++; end
    for (int i = 0; i < 5; i++) put(8'($urandom_range(8'h7E, 8'h21)), 8'($urandom));
    ls = log_addr.size();
    put(CC_CR, 8'h55);
    checks++;
    if (cursor_x !== 8'd0 || cursor_y !== 8'd3 || log_addr.size() != ls) begin errors++;
      $display("FAIL cr: cursor (%0d,%0d) writes %0d, need (0,3) 0", cursor_x, cursor_y, log_addr.size() - ls); end
    put(CC_LF, 8'h55);
    checks++;
    if (cursor_x !== 8'd0 || cursor_y !== 8'd4 || log_addr.size() != ls) begin errors++;
      $display("FAIL lf: cursor (%0d,%0d) writes %0d, need (0,4) 0", cursor_x, cursor_y, log_addr.size() - ls); end
  endtask

  task automatic test_clear();
    int acc, ls, n, bad, fi, nd;
    bit seen;
    busy_mode = 1;
    ls = log_addr.size();
    send_char(CC_FF, 8'h00, acc);
    seen = 1'b0; n = 0;
    do begin @(negedge clk); n++; if (op_busy) seen = 1'b1; end
    while (!(char_ready && !op_busy) && n < LIMIT);
    checks++;
    if (n >= LIMIT || !seen) begin errors++;
      $display("FAIL clear_run: cycles %0d op_busy_seen %0b, need done and 1", n, seen); end
    checks++;
    if (log_addr.size() - ls !== CELLS) begin errors++;
      $display("FAIL clear_count: %0d writes, need %0d", log_addr.size() - ls, CELLS);
    end else begin
      bad = 0;
      for (int k = 0; k < CELLS; k++)
        if (log_addr[ls + k] !== 16'(k) || log_data[ls + k] !== CLR) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL clear_sequence: %0d bad writes, need 0", bad); end
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL clear_busy_we: %0d strobes while busy, need 0", viol); end
    checks++;
    if (cursor_x !== 8'd0 || cursor_y !== 8'd0) begin errors++;
      $display("FAIL clear_cursor: got (%0d,%0d), need (0,0)", cursor_x, cursor_y); end
    nd = mem_diffs(fi);
    checks++;
    if (nd != 0) begin errors++;
      $display("FAIL clear_mem: %0d cells differ, first %0d got %h need %h", nd, fi, mem[fi], exp_mem[fi]); end
    busy_mode = 0;
  endtask

  task automatic test_random();
    int r, fi, nd;
    logic [7:0] c;
    busy_mode = 2;
    put(CC_FF, 8'h00);
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(99);
      if (r < 8) c = CC_LF;
      else if (r < 16) c = CC_CR;
      else if (r < 17) c = CC_FF;
      else begin
        c = 8'($urandom);
        if (c == CC_LF || c == CC_CR || c == CC_FF) c = 8'h7F;
      end
      put(c, 8'($urandom));
      checks++;
      if (cursor_x !== 8'(mx) || cursor_y !== 8'(my)) begin errors++;
        $display("FAIL random_cursor[%0d]: byte %h got (%0d,%0d), need (%0d,%0d)", i, c, cursor_x, cursor_y, mx, my); end
    end
    nd = mem_diffs(fi);
    checks++;
    if (nd != 0) begin errors++;
      $display("FAIL random_mem: %0d cells differ, first %0d got %h need %h", nd, fi, mem[fi], exp_mem[fi]); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL random_busy_we: %0d strobes while busy, need 0", viol); end
  endtask

  task automatic test_row_end();
    int guard, fi, nd;
    logic [15:0] row0_first, row1_first;
    logic [7:0] c, a;
    busy_mode = 2;
    put(CC_FF, 8'h00);
    c = 8'h61; a = 8'($urandom);
    row0_first = {a, c};
    put(c, a);
    for (int i = 0; i < 9; i++) put(8'($urandom_range(8'h7E, 8'h21)), 8'($urandom));
    put(CC_LF, 8'h00);
    c = 8'h62; a = 8'($urandom);
    row1_first = {a, c};
    put(c, a);
    for (int i = 1; i < COLS; i++) put(8'($urandom_range(8'h7E, 8'h21)), 8'($urandom));
    guard = 0;
    while (my != ROWS - 1 && guard < ROWS) begin put(CC_LF, 8'h00); guard++; end
    for (int i = 0; i < 7; i++) put(8'($urandom_range(8'h7E, 8'h21)), 8'($urandom));
    put(CC_CR, 8'h00);
    put(CC_LF, 8'h00);
    checks++;
    if (cursor_x !== 8'd0 || cursor_y !== (SCROLL ? 8'd29 : 8'd0)) begin errors++;
      $display("FAIL row_end_cursor: got (%0d,%0d), need (0,%0d)", cursor_x, cursor_y, SCROLL ? 29 : 0); end
    checks++;
    if (mem[0] !== (SCROLL ? row1_first : row0_first)) begin errors++;
      $display("FAIL row_end_cell0: got %h, need %h", mem[0], SCROLL ? row1_first : row0_first); end
    nd = mem_diffs(fi);
    checks++;
    if (nd != 0) begin errors++;
      $display("FAIL row_end_mem: %0d cells differ, first %0d got %h need %h", nd, fi, mem[fi], exp_mem[fi]); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL row_end_busy_we: %0d strobes while busy, need 0", viol); end
    busy_mode = 0;
  endtask

  task automatic test_reset_mid_clear();
    int acc, ls, n;
    busy_mode = 0;
    put(8'h31, 8'h02);
    ls = log_addr.size();
    send_char(CC_FF, 8'h00, acc);
    n = 0;
    while (log_addr.size() - ls < 100 && n < LIMIT) begin @(negedge clk); n++; end
    checks++;
    if (n >= LIMIT) begin errors++; $display("FAIL abort_reach: only %0d clear writes, need 100", log_addr.size() - ls); end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({char_ready, ram_writeenable, op_busy} !== 3'b000 || ram_addr !== 16'h0000 || ram_write !== 16'h0000) begin
      errors++;
      $display("FAIL abort_outputs: ready/we/busy=%b addr %h data %h, need 000 0000 0000",
               {char_ready, ram_writeenable, op_busy}, ram_addr, ram_write);
    end
    checks++;
    if (cursor_x !== 8'd0 || cursor_y !== 8'd0) begin errors++;
      $display("FAIL abort_cursor: got (%0d,%0d), need (0,0)", cursor_x, cursor_y); end
    @(negedge clk);
    reset = 1'b1;
    mx = 0; my = 0;
    @(negedge clk);
    checks++;
    if (char_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, need 1", char_ready); end
    ls = log_addr.size();
    put(8'h5A, 8'h1E);
    checks++;
    if (log_addr.size() - ls !== 1 || log_addr[ls] !== 16'h0000 || log_data[ls] !== 16'h1E5A || cursor_x !== 8'd1) begin
      errors++;
      $display("FAIL abort_resume: writes %0d cursor_x %0d, need 1 write of 1e5a at 0000 and cursor_x 1",
               log_addr.size() - ls, cursor_x);
    end
  endtask

  initial begin
    test_reset();
    test_first_char();
    test_row_wrap();
    test_cr_lf();
    test_clear();
    test_random();
    test_row_end();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_ram_writer.md
Name: tile_ram_writer

Overview:
- Write-side client of the tile-map RAM that the tile renderer reads.
- Accepts character/attribute pairs over a valid/ready handshake and writes 16-bit tile words at a managed cursor: low byte = char code, high byte = attribute.
- Interprets control codes for newline, carriage return and clear-screen.
- Accesses RAM only in cycles where the renderer does not own it (ram_busy low). The top level muxes ram_addr on ram_busy.

Parameters:
- COLS, 32, tile columns per row.
- ROWS, 30, tile rows.
- BASE_ADDR, 16'h0000, RAM word address of cell (0,0).
- CLEAR_WORD, 16'h0020, word written by clear operations (space, attribute 0).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- char_valid  in  1  input character present
- char_data  in  8  character code or control code
- char_attr  in  8  attribute byte stored in tile high byte
- char_ready  out  1  block accepts char this cycle
- ram_busy  in  1  renderer owns RAM this cycle; writer must not access
- ram_addr  out  16  writer RAM word address
- ram_write  out  16  write data
- ram_writeenable  out  1  write strobe
- ram_read  in  16  RAM read data, valid one cycle after address (sync RAM)
- cursor_x  out  8  current column
- cursor_y  out  8  current row
- op_busy  out  1  multi-cycle operation (clear/scroll) in progress

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; cursor_x=cursor_y=0.
  - ram_addr=BASE_ADDR, ram_write=0, ram_writeenable=0.
  - char_ready=0, op_busy=0.
- Address rule: cell address = BASE_ADDR + cursor_y*COLS + cursor_x, computed mod 2^16.
- IDLE:
  - char_ready=1 when state is IDLE.
  - A char is accepted when char_valid&&char_ready, then IDLE goes to DECODE. char_ready drops the cycle after acceptance.
- DECODE, based on the captured byte:
  - 0x0A (LF): cursor_x=0, cursor_y+1; goes to IDLE or ROW_END.
  - 0x0D (CR): cursor_x=0; goes to IDLE.
  - 0x0C (FF): goes to CLEAR; cursors reset to 0 after the clear completes.
  - Any other byte: goes to WRITE.
- WRITE:
  - Waits while ram_busy=1.
  - On the first cycle with ram_busy=0, drives addr/data with writeenable=1 for exactly one cycle.
  - Then advances cursor_x. If cursor_x reaches COLS, cursor_x=0 and the row is advanced.
- Row advance past ROWS-1: go to ROW_END (behaviour depends on the optional feature).
- CLEAR:
  - Sweeps addresses BASE_ADDR..BASE_ADDR+COLS*ROWS-1, writing CLEAR_WORD.
  - Exactly one write per ram_busy=0 cycle; no writes while ram_busy=1; the index is held.
  - op_busy=1 for the duration of the sweep.
- ram_writeenable is never 1 in a cycle where ram_busy=1. ram_busy rising mid-operation stalls the operation with no lost or duplicated cells.
- Latency: a printable char accepted with ram_busy held 0 is written 2 cycles after the acceptance edge. char_ready returns 1 in the next cycle.
- char_valid while busy: ignored (char_ready=0). The producer holds the char.
- Reset mid-operation aborts immediately. Partially cleared or scrolled RAM is left as-is.

Optional Feature:
- Macro: TILE_RAM_WRITER_SCROLL_EN.
- Defined:
  - ROW_END scrolls up: for each cell in rows 1..ROWS-1, read it (SCROLL_RD, address issued, data captured 1 cycle later) and write it to the cell one row up (SCROLL_WR). Each access requires ram_busy=0.
  - Row ROWS-1 is then filled with CLEAR_WORD.
  - cursor_y=ROWS-1, cursor_x=0; op_busy=1 throughout.
  - A read whose data cycle coincides with ram_busy=1 is reissued.
- Undefined:
  - ROW_END sets cursor_y=0 with no RAM traffic; ram_read is unused.

Decomposition:
- Shared package holds:
  - state enum (IDLE, DECODE, WRITE, CLEAR, ROW_END, SCROLL_RD, SCROLL_WR, SCROLL_CLR);
  - control-code constants CC_LF=8'h0A, CC_CR=8'h0D, CC_FF=8'h0C;
  - the tile word layout (char [7:0], attr [15:8]).
- One sub-module is natural: tile_cursor — cursor counters, wrap detection and cell-address computation.

Test Plan:
- Reset, then send 'A' (0x41) attr 0x07 with ram_busy=0 → one write: addr 0x0000, data 0x0741; cursor_x=1.
- Send 32 chars 'B' → the 32nd write goes to addr 0x001F; cursor_x=0, cursor_y=1.
- Send 0x0C with ram_busy toggling 1/0 each cycle → exactly 960 writes of 0x0020 to 0x0000..0x03BF; no writeenable while ram_busy=1; cursors end at 0,0.
- Cursor at (5,3): send 0x0D → cursor (0,3), no RAM write. Then send 0x0A → cursor (0,4), no RAM write.
- Cursor at row 29, send LF:
  - Scroll defined: RAM[0x0000..]=old row 1; row 29 cleared to 0x0020; cursor_y=29.
  - Scroll undefined: cursor_y=0, RAM unchanged.
- Assert reset during CLEAR at index 100 → outputs return to reset values asynchronously; char_ready=1 after release.
